// File: rtl/dafx_amplitude_pkg.sv
// Shared types and default constants for the
// amplitude monitor slice.
package dafx_amplitude_pkg;

  typedef enum logic {
    EMPTY_E,
    TRACKING_E
  } amp_state_t;

  localparam int CLIP_LEVEL_DEF_C = (1 << 23) - (1 << 16);
  localparam int CLIP_COUNT_DEF_C = 4;

endpackage

// File: rtl/dafx_amplitude_tracker.sv
// One audio channel: running min/max, clip
// counter and sticky clip interrupt.
module dafx_amplitude_tracker
  import dafx_amplitude_pkg::*;
#(
  parameter int AUDIO_WIDTH_C = 24,
  parameter int CLIP_LEVEL_C  = CLIP_LEVEL_DEF_C,
  parameter int CLIP_COUNT_C  = CLIP_COUNT_DEF_C
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AUDIO_WIDTH_C-1:0] data,
  input  logic                     valid,
  input  logic                     clear_amp,
  input  logic                     clear_irq,
  output logic [AUDIO_WIDTH_C-1:0] min_amp,
  output logic [AUDIO_WIDTH_C-1:0] max_amp,
  output logic                     irq
);

  localparam int W  = AUDIO_WIDTH_C;
  localparam int CW = $clog2(CLIP_COUNT_C + 1);

  localparam logic [CW-1:0] CNT_MAX =
    CW'(CLIP_COUNT_C);
  localparam logic [W:0] LEVEL =
    (W + 1)'(CLIP_LEVEL_C);

  amp_state_t    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic [W:0]    ext;
  logic [W:0]    mag;
  logic          clip;
  logic          hit;
  logic          lt_min;
  logic          gt_max;

  // One extra bit keeps |most-negative| representable.
  always_comb begin
    ext     = {data[W-1], data};
    mag     = ext[W] ? -ext : ext;
    clip    = mag >= LEVEL;
    cnt_nxt = cnt;
    if (valid) begin
      if (!clip)
        cnt_nxt = '0;
      else if (cnt != CNT_MAX)
        cnt_nxt = cnt + CW'(1);
    end
    hit    = valid && clip && (cnt_nxt == CNT_MAX);
    lt_min = $signed(data) < $signed(min_amp);
    gt_max = $signed(data) > $signed(max_amp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= EMPTY_E;
      min_amp <= '0;
      max_amp <= '0;
      cnt     <= '0;
      irq     <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (hit)
        irq <= 1'b1;
      else if (clear_irq)
        irq <= 1'b0;

      if (clear_amp) begin
        state   <= valid ? TRACKING_E : EMPTY_E;
        min_amp <= valid ? data : '0;
        max_amp <= valid ? data : '0;
      end else if (valid) begin
        case (state)
          EMPTY_E: begin
            state   <= TRACKING_E;
            min_amp <= data;
            max_amp <= data;
          end
          TRACKING_E: begin
            if (lt_min)
              min_amp <= data;
            if (gt_max)
              max_amp <= data;
          end
          default: state <= EMPTY_E;
        endcase
      end
    end
  end

endmodule

// File: rtl/dafx_amplitude_monitor.sv
// ADC/DAC amplitude monitor: two independent
// trackers feeding the register slave.
module dafx_amplitude_monitor
  import dafx_amplitude_pkg::*;
#(
  parameter int AUDIO_WIDTH_C = 24,
  parameter int CLIP_LEVEL_C  = CLIP_LEVEL_DEF_C,
  parameter int CLIP_COUNT_C  = CLIP_COUNT_DEF_C
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [AUDIO_WIDTH_C-1:0] adc_data,
  input  logic                     adc_valid,
  input  logic [AUDIO_WIDTH_C-1:0] dac_data,
  input  logic                     dac_valid,
  input  logic                     cmd_clear_adc_amplitude,
  input  logic                     cmd_clear_dac_amplitude,
  input  logic                     cmd_clear_irq_0,
  input  logic                     cmd_clear_irq_1,
  output logic [AUDIO_WIDTH_C-1:0] sr_cir_min_adc_amplitude,
  output logic [AUDIO_WIDTH_C-1:0] sr_cir_max_adc_amplitude,
  output logic [AUDIO_WIDTH_C-1:0] sr_cir_min_dac_amplitude,
  output logic [AUDIO_WIDTH_C-1:0] sr_cir_max_dac_amplitude,
  output logic                     irq_0,
  output logic                     irq_1
);

  dafx_amplitude_tracker #(
    .AUDIO_WIDTH_C(AUDIO_WIDTH_C),
    .CLIP_LEVEL_C (CLIP_LEVEL_C),
    .CLIP_COUNT_C (CLIP_COUNT_C)
  ) u_adc (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (adc_data),
    .valid    (adc_valid),
    .clear_amp(cmd_clear_adc_amplitude),
    .clear_irq(cmd_clear_irq_0),
    .min_amp  (sr_cir_min_adc_amplitude),
    .max_amp  (sr_cir_max_adc_amplitude),
    .irq      (irq_0)
  );

  dafx_amplitude_tracker #(
    .AUDIO_WIDTH_C(AUDIO_WIDTH_C),
    .CLIP_LEVEL_C (CLIP_LEVEL_C),
    .CLIP_COUNT_C (CLIP_COUNT_C)
  ) u_dac (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (dac_data),
    .valid    (dac_valid),
    .clear_amp(cmd_clear_dac_amplitude),
    .clear_irq(cmd_clear_irq_1),
    .min_amp  (sr_cir_min_dac_amplitude),
    .max_amp  (sr_cir_max_dac_amplitude),
    .irq      (irq_1)
  );

endmodule
